// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, hands words to the control
// unit over valid/ready, applies redirects and keeps a circular return-address stack.
module instr_fetch_unit #(
  parameter int                ADDR_W    = 16,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [31:0]       i_imem_rdata,
  input  logic              i_imem_valid,
  output logic [31:0]       o_instr,
  output logic [5:0]        o_opcode,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  input  logic              i_write_pc,
  input  logic [1:0]        i_branch,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_cond_flag,
  input  logic [ADDR_W-1:0] i_target_in,
  input  logic              i_halt,
  output logic              o_halted,
  output logic              o_ras_err
);

  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = SP_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_pc_out;
  logic [31:0]         r_instr;
  logic [ADDR_W-1:0]   r_ras [RAS_DEPTH];
  logic [SP_W-1:0]     r_ras_sp;
  logic [CNT_W-1:0]    r_ras_cnt;
  logic                r_ras_err;

  logic                w_fetch_done;
  logic                w_accept;
  logic                w_redirect;
  logic                w_ras_push;
  logic                w_ras_pop;
  logic                w_ras_empty;
  logic                w_ras_full;
  logic [SP_W-1:0]     w_ras_top_idx;
  logic [ADDR_W-1:0]   w_seq_pc;
  logic [ADDR_W-1:0]   w_pc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    o_halted      = 1'b0;
    w_fetch_done  = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_WAIT;
      S_WAIT: begin
        o_imem_req = 1'b1;
        if (i_imem_valid) begin
          w_fetch_done = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        o_instr_valid = 1'b1;
        if (i_instr_ready) begin
          w_accept     = 1'b1;
          w_state_next = i_halt ? S_HALT : S_WAIT;
        end
      end
      S_HALT: o_halted = 1'b1;
      default: w_state_next = S_IDLE;
    endcase
  end

  // A halting accept falls through sequentially and leaves the stack alone.
  assign w_redirect    = i_write_pc & ~i_halt;
  assign w_ras_pop     = w_redirect & (i_branch == 2'b01) & i_pop;
  assign w_ras_push    = w_redirect & (i_branch == 2'b01) & i_push & ~i_pop;
  assign w_ras_empty   = (r_ras_cnt == '0);
  assign w_ras_full    = (r_ras_cnt == CNT_W'(RAS_DEPTH));
  assign w_ras_top_idx = r_ras_sp - SP_W'(1);
  assign w_seq_pc      = r_pc_out + ADDR_W'(1);

  always_comb begin
    w_pc_next = w_seq_pc;
    if (w_redirect) begin
      case (i_branch)
        2'b01: begin
          if (i_pop) begin
            w_pc_next = w_ras_empty ? RESET_PC : r_ras[w_ras_top_idx];
          end else begin
            w_pc_next = i_target_in;
          end
        end
        2'b10:   w_pc_next = i_cond_flag ? (w_seq_pc + i_target_in) : w_seq_pc;
        2'b11:   w_pc_next = i_target_in;
        default: w_pc_next = w_seq_pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_pc_out  <= RESET_PC;
      r_instr   <= '0;
      r_ras_sp  <= '0;
      r_ras_cnt <= '0;
      r_ras_err <= 1'b0;
    end else begin
      if (w_fetch_done) begin
        r_instr  <= i_imem_rdata;
        r_pc_out <= r_pc;
      end
      if (w_accept) begin
        r_pc <= w_pc_next;
        // When full the write slot at the stack pointer is the oldest entry.
        if (w_ras_push) begin
          r_ras_sp <= r_ras_sp + SP_W'(1);
          if (w_ras_full) begin
            r_ras_err <= 1'b1;
          end else begin
            r_ras_cnt <= r_ras_cnt + CNT_W'(1);
          end
        end else if (w_ras_pop) begin
          if (w_ras_empty) begin
            r_ras_err <= 1'b1;
          end else begin
            r_ras_sp  <= w_ras_top_idx;
            r_ras_cnt <= r_ras_cnt - CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_ras_push) begin
      r_ras[r_ras_sp] <= w_seq_pc;
    end
  end

  assign o_imem_addr = r_pc;
  assign o_instr     = r_instr;
  assign o_opcode    = r_instr[31:26];
  assign o_pc_out    = r_pc_out;
  assign o_ras_err   = r_ras_err;

endmodule
